// File: rtl/connect4_pkg.sv
// Shared Connect 4 definitions: piece codes, board size, scan directions and scanner states.
package connect4_pkg;

  localparam int unsigned ROWS = 6;
  localparam int unsigned COLS = 7;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P1    = 2'b01;
  localparam logic [1:0] P2    = 2'b10;

  typedef struct packed {
    logic signed [3:0] drow;
    logic signed [3:0] dcol;
  } delta_t;

  localparam delta_t DELTA_HORZ    = '{drow: 4'sd0,  dcol: 4'sd1};
  localparam delta_t DELTA_VERT    = '{drow: 4'sd1,  dcol: 4'sd0};
  localparam delta_t DELTA_DIAG_DN = '{drow: 4'sd1,  dcol: 4'sd1};
  localparam delta_t DELTA_DIAG_UP = '{drow: -4'sd1, dcol: 4'sd1};

  typedef enum logic [2:0] {
    StIdle,
    StDir,
    StIssue,
    StCmp,
    StDone
  } scan_state_e;

  function automatic delta_t dir_delta(input logic [1:0] dir);
    case (dir)
      2'd0:    return DELTA_HORZ;
      2'd1:    return DELTA_VERT;
      2'd2:    return DELTA_DIAG_DN;
      default: return DELTA_DIAG_UP;
    endcase
  endfunction

endpackage

// File: rtl/win_addr_calc.sv
// Combinational target-cell calculator: origin + sign*step*delta, bounds check and flat address.
module win_addr_calc #(
  parameter int unsigned ROWS = 6,
  parameter int unsigned COLS = 7
) (
  input  logic [2:0]        org_row,
  input  logic [2:0]        org_col,
  input  logic [1:0]        dir,
  input  logic              sign,
  input  logic [1:0]        step,
  output logic signed [3:0] tgt_row,
  output logic signed [3:0] tgt_col,
  output logic              in_bounds,
  output logic [5:0]        rd_addr
);
  import connect4_pkg::*;

  localparam logic signed [3:0] RowLim = 4'(ROWS);
  localparam logic signed [3:0] ColLim = 4'(COLS);
  localparam logic [5:0]        ColsW  = 6'(COLS);

  delta_t            delta;
  logic signed [3:0] step_s;
  logic signed [3:0] off_row;
  logic signed [3:0] off_col;

  // Step only reaches 3 after in-bounds steps 1 and 2, so 4-bit targets never wrap into range.
  always_comb begin
    delta   = dir_delta(dir);
    step_s  = $signed({2'b00, step});
    off_row = step_s * delta.drow;
    off_col = step_s * delta.dcol;
    if (sign) begin
      off_row = -off_row;
      off_col = -off_col;
    end
    tgt_row   = $signed({1'b0, org_row}) + off_row;
    tgt_col   = $signed({1'b0, org_col}) + off_col;
    in_bounds = (tgt_row >= 4'sd0) && (tgt_row < RowLim) &&
                (tgt_col >= 4'sd0) && (tgt_col < ColLim);
  end

  assign rd_addr = ({3'b000, tgt_row[2:0]} * ColsW) + {3'b000, tgt_col[2:0]};

endmodule

// File: rtl/win_scanner.sv
// Four-in-a-row detector: walks the board around the placed piece via a single-port read
// interface and reports win/done to the game FSM.
module win_scanner #(
  parameter int unsigned ROWS = 6,
  parameter int unsigned COLS = 7
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic       start,
  input  logic [2:0] row,
  input  logic [2:0] col,
  input  logic [1:0] player,
  output logic       rd_en,
  output logic [5:0] rd_addr,
  input  logic [1:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       win,
  output logic [1:0] win_dir
);
  import connect4_pkg::*;

  localparam logic [3:0] RowsW = 4'(ROWS);
  localparam logic [3:0] ColsW = 4'(COLS);

  scan_state_e state_q, state_d;
  logic [2:0]  org_row_q, org_row_d;
  logic [2:0]  org_col_q, org_col_d;
  logic [1:0]  player_q, player_d;
  logic [1:0]  dir_q, dir_d;
  logic        sign_q, sign_d;
  logic [1:0]  step_q, step_d;
  logic [2:0]  count_q, count_d;
  logic        win_q, win_d;
  logic [1:0]  win_dir_q, win_dir_d;

  logic              start_ok;
  logic              in_bounds;
  logic [5:0]        calc_addr;
  logic signed [3:0] tgt_row;
  logic signed [3:0] tgt_col;
  logic              leg_end;
  logic              match;
  logic [2:0]        count_inc;

  win_addr_calc #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_addr_calc (
    .org_row   (org_row_q),
    .org_col   (org_col_q),
    .dir       (dir_q),
    .sign      (sign_q),
    .step      (step_q),
    .tgt_row   (tgt_row),
    .tgt_col   (tgt_col),
    .in_bounds (in_bounds),
    .rd_addr   (calc_addr)
  );

  // Target coordinates are only needed through the bounds flag and address.
  logic unused_tgt;
  assign unused_tgt = ^{tgt_row, tgt_col};

  assign start_ok = ({1'b0, row} < RowsW) && ({1'b0, col} < ColsW) &&
                    ((player == P1) || (player == P2));

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q   <= StIdle;
      org_row_q <= '0;
      org_col_q <= '0;
      player_q  <= '0;
      dir_q     <= '0;
      sign_q    <= 1'b0;
      step_q    <= '0;
      count_q   <= '0;
      win_q     <= 1'b0;
      win_dir_q <= '0;
    end else begin
      state_q   <= state_d;
      org_row_q <= org_row_d;
      org_col_q <= org_col_d;
      player_q  <= player_d;
      dir_q     <= dir_d;
      sign_q    <= sign_d;
      step_q    <= step_d;
      count_q   <= count_d;
      win_q     <= win_d;
      win_dir_q <= win_dir_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    org_row_d = org_row_q;
    org_col_d = org_col_q;
    player_d  = player_q;
    dir_d     = dir_q;
    sign_d    = sign_q;
    step_d    = step_q;
    count_d   = count_q;
    win_d     = win_q;
    win_dir_d = win_dir_q;
    leg_end   = 1'b0;
    match     = (rd_data == player_q);
    count_inc = count_q + 3'd1;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          org_row_d = row;
          org_col_d = col;
          player_d  = player;
          dir_d     = 2'd0;
          win_d     = 1'b0;
          win_dir_d = 2'd0;
          state_d   = start_ok ? StDir : StDone;
        end
      end
      StDir: begin
        count_d = 3'd1;
        sign_d  = 1'b0;
        step_d  = 2'd1;
        state_d = StIssue;
      end
      StIssue: begin
        if (in_bounds) state_d = StCmp;
        else           leg_end = 1'b1;
      end
      StCmp: begin
        if (match) count_d = count_inc;
        if (match && (count_inc == 3'd4)) begin
          win_d     = 1'b1;
          win_dir_d = dir_q;
          state_d   = StDone;
        end else if (match && (step_q != 2'd3)) begin
          step_d  = step_q + 2'd1;
          state_d = StIssue;
        end else begin
          leg_end = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A finished + leg turns around; a finished - leg moves on to the next direction.
    if (leg_end) begin
      if (!sign_q) begin
        sign_d  = 1'b1;
        step_d  = 2'd1;
        state_d = StIssue;
      end else if (dir_q != 2'd3) begin
        dir_d   = dir_q + 2'd1;
        state_d = StDir;
      end else begin
        state_d = StDone;
      end
    end
  end

  always_comb begin
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
    rd_en   = (state_q == StIssue) && in_bounds;
    rd_addr = rd_en ? calc_addr : 6'd0;
    win     = win_q;
    win_dir = win_dir_q;
  end

endmodule

// File: tb/tb_win_scanner.sv
// Self-checking bench for win_scanner: directed scenarios plus random boards vs a board model.
module tb_win_scanner;

  logic       CLOCK_50 = 1'b0;
  logic       Reset;
  logic       start;
  logic [2:0] row;
  logic [2:0] col;
  logic [1:0] player;
  logic       rd_en;
  logic [5:0] rd_addr;
  logic [1:0] rd_data;
  logic       busy;
  logic       done;
  logic       win;
  logic [1:0] win_dir;

  int checks = 0;
  int errors = 0;

  logic [1:0] board [42];
  int reads[$];
  int exp_reads[$];
  int exp_win, exp_dir, exp_lat;
  int act_win, act_dir, act_lat, done_after, busy_after, win_after;

  win_scanner dut (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .start    (start),
    .row      (row),
    .col      (col),
    .player   (player),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .win      (win),
    .win_dir  (win_dir)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Board memory: one-cycle read latency, garbage whenever no read was issued.
  always @(posedge CLOCK_50) begin
    if (rd_en) begin
      reads.push_back(int'(rd_addr));
      rd_data <= (rd_addr < 6'd42) ? board[rd_addr] : 2'b11;
    end else begin
      rd_data <= 2'($urandom);
    end
  end

  function automatic int drow_of(input int d);
    case (d)
      0:       return 0;
      1:       return 1;
      2:       return 1;
      default: return -1;
    endcase
  endfunction

  function automatic int dcol_of(input int d);
    return (d == 1) ? 0 : 1;
  endfunction

  function automatic bit reads_equal();
    if (reads.size() != exp_reads.size()) return 0;
    foreach (reads[i]) if (reads[i] != exp_reads[i]) return 0;
    return 1;
  endfunction

  function automatic string fmt_q(input bit use_exp);
    string s = "{";
    if (use_exp) foreach (exp_reads[i]) s = {s, $sformatf(" %0d", exp_reads[i])};
    else         foreach (reads[i])     s = {s, $sformatf(" %0d", reads[i])};
    return {s, " }"};
  endfunction

  // Reference: walk each direction outward, count contiguous pieces, tally cycle cost.
  task automatic model_scan(input int r, input int c, input int p);
    int work, cnt, tr, tc, s;
    exp_reads.delete();
    exp_win = 0;
    exp_dir = 0;
    exp_lat = 1;
    if (r >= 6 || c >= 7 || !(p == 1 || p == 2)) return;
    work = 0;
    for (int d = 0; d < 4; d++) begin
      work += 1;
      cnt = 1;
      for (int si = 0; si < 2; si++) begin
        s = (si == 0) ? 1 : -1;
        for (int k = 1; k <= 3; k++) begin
          tr = r + s * k * drow_of(d);
          tc = c + s * k * dcol_of(d);
          if (tr < 0 || tr >= 6 || tc < 0 || tc >= 7) begin
            work += 1;
            break;
          end
          exp_reads.push_back(tr * 7 + tc);
          work += 2;
          if (int'(board[tr * 7 + tc]) == p) begin
            cnt++;
            if (cnt == 4) begin
              exp_win = 1;
              exp_dir = d;
              exp_lat = work + 1;
              return;
            end
          end else begin
            break;
          end
        end
      end
    end
    exp_lat = work + 1;
  endtask

  task automatic clear_board();
    for (int i = 0; i < 42; i++) board[i] = 2'b00;
  endtask

  // Drive one start pulse and wait (bounded) for done; optionally poke start while busy or in DONE.
  task automatic run_scan(input int r, input int c, input int p, input int poke_cyc,
                          input bit poke_done);
    reads.delete();
    act_lat = -1;
    act_win = -1;
    act_dir = -1;
    @(negedge CLOCK_50);
    row = 3'(r); col = 3'(c); player = 2'(p); start = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge CLOCK_50);
      start = 1'b0;
      if (done) begin
        act_lat = cyc;
        act_win = int'(win);
        act_dir = int'(win_dir);
        break;
      end
      if (cyc == poke_cyc) begin
        row = 3'd0; col = 3'd0; player = 2'b10; start = 1'b1;
      end
    end
    if (poke_done) begin
      row = 3'd5; col = 3'd0; player = 2'b01; start = 1'b1;
    end
    @(negedge CLOCK_50);
    start = 1'b0;
    done_after = int'(done);
    busy_after = int'(busy);
    win_after  = int'(win);
  endtask

  task automatic test_reset();
    Reset = 1'b1; start = 1'b1; row = 3'd5; col = 3'd0; player = 2'b01;
    repeat (3) @(negedge CLOCK_50);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
    checks++; if (rd_addr !== 6'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
    checks++; if (win !== 1'b0) begin errors++; $display("FAIL reset_win: got %b want 0", win); end
    checks++; if (win_dir !== 2'd0) begin errors++; $display("FAIL reset_win_dir: got %0d want 0", win_dir); end
    start = 1'b0;
    Reset = 1'b0;
    @(negedge CLOCK_50);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_empty_board();
    clear_board();
    run_scan(5, 0, 1, 0, 0);
    exp_reads = '{36, 28, 29};
    checks++; if (!reads_equal()) begin errors++; $display("FAIL empty_reads: got %s want %s", fmt_q(0), fmt_q(1)); end
    checks++; if (act_lat != 16) begin errors++; $display("FAIL empty_latency: got %0d want 16", act_lat); end
    checks++; if (act_win != 0) begin errors++; $display("FAIL empty_win: got %0d want 0", act_win); end
    checks++; if (done_after != 0) begin errors++; $display("FAIL empty_done_width: got %0d want 0", done_after); end
    checks++; if (busy_after != 0) begin errors++; $display("FAIL empty_busy_after: got %0d want 0", busy_after); end
  endtask

  task automatic setup_horizontal();
    clear_board();
    board[35] = 2'b01; board[36] = 2'b01; board[37] = 2'b01;
  endtask

  task automatic test_horizontal_win();
    setup_horizontal();
    run_scan(5, 3, 1, 0, 0);
    exp_reads = '{39, 37, 36, 35};
    checks++; if (!reads_equal()) begin errors++; $display("FAIL horz_reads: got %s want %s", fmt_q(0), fmt_q(1)); end
    checks++; if (act_win != 1) begin errors++; $display("FAIL horz_win: got %0d want 1", act_win); end
    checks++; if (act_dir != 0) begin errors++; $display("FAIL horz_dir: got %0d want 0", act_dir); end
    checks++; if (act_lat != 10) begin errors++; $display("FAIL horz_latency: got %0d want 10", act_lat); end
    checks++; if (done_after != 0) begin errors++; $display("FAIL horz_done_once: got %0d want 0", done_after); end
    checks++; if (win_after != 1) begin errors++; $display("FAIL horz_win_held: got %0d want 1", win_after); end
  endtask

  task automatic test_vertical_win();
    clear_board();
    board[21] = 2'b10; board[28] = 2'b10; board[35] = 2'b10;
    run_scan(2, 0, 2, 0, 0);
    exp_reads = '{15, 21, 28, 35};
    checks++; if (!reads_equal()) begin errors++; $display("FAIL vert_reads: got %s want %s", fmt_q(0), fmt_q(1)); end
    checks++; if (act_win != 1) begin errors++; $display("FAIL vert_win: got %0d want 1", act_win); end
    checks++; if (act_dir != 1) begin errors++; $display("FAIL vert_dir: got %0d want 1", act_dir); end
    checks++; if (act_lat != 12) begin errors++; $display("FAIL vert_latency: got %0d want 12", act_lat); end
  endtask

  task automatic test_color_check();
    clear_board();
    board[35] = 2'b10; board[29] = 2'b10; board[23] = 2'b10; board[17] = 2'b01;
    model_scan(2, 3, 1);
    run_scan(2, 3, 1, 0, 0);
    checks++; if (act_win != 0) begin errors++; $display("FAIL color_win: got %0d want 0", act_win); end
    checks++; if (act_dir != 0) begin errors++; $display("FAIL color_dir: got %0d want 0", act_dir); end
    checks++; if (act_lat != exp_lat) begin errors++; $display("FAIL color_latency: got %0d want %0d", act_lat, exp_lat); end
    checks++; if (!reads_equal()) begin errors++; $display("FAIL color_reads: got %s want %s", fmt_q(0), fmt_q(1)); end
  endtask

  task automatic test_start_while_busy();
    setup_horizontal();
    run_scan(5, 3, 1, 3, 0);
    exp_reads = '{39, 37, 36, 35};
    checks++; if (!reads_equal()) begin errors++; $display("FAIL busy_start_reads: got %s want %s", fmt_q(0), fmt_q(1)); end
    checks++; if (act_win != 1) begin errors++; $display("FAIL busy_start_win: got %0d want 1", act_win); end
    checks++; if (act_lat != 10) begin errors++; $display("FAIL busy_start_latency: got %0d want 10", act_lat); end
    checks++; if (busy_after != 0) begin errors++; $display("FAIL busy_start_queued: got %0d want 0", busy_after); end
  endtask

  task automatic test_back_to_back();
    setup_horizontal();
    run_scan(5, 3, 1, 0, 1);
    checks++; if (busy_after != 0) begin errors++; $display("FAIL b2b_start_in_done: busy got %0d want 0", busy_after); end
    checks++; if (win_after != 1) begin errors++; $display("FAIL b2b_win_kept: got %0d want 1", win_after); end
    clear_board();
    run_scan(5, 0, 1, 0, 0);
    checks++; if (act_lat != 16) begin errors++; $display("FAIL b2b_next_latency: got %0d want 16", act_lat); end
    checks++; if (act_win != 0) begin errors++; $display("FAIL b2b_next_win: got %0d want 0", act_win); end
  endtask

  task automatic test_reset_mid_scan();
    int dones;
    clear_board();
    @(negedge CLOCK_50);
    row = 3'd5; col = 3'd0; player = 2'b01; start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    Reset = 1'b1;
    @(negedge CLOCK_50);
    Reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL midreset_rd_en: got %b want 0", rd_en); end
    checks++; if (win !== 1'b0) begin errors++; $display("FAIL midreset_win: got %b want 0", win); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      @(negedge CLOCK_50);
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses want 0", dones); end
  endtask

  task automatic test_bad_start();
    int bad_r[4] = '{5, 6, 0, 0};
    int bad_c[4] = '{7, 0, 0, 3};
    int bad_p[4] = '{1, 1, 3, 0};
    for (int i = 0; i < 4; i++) begin
      setup_horizontal();
      run_scan(5, 3, 1, 0, 0);
      run_scan(bad_r[i], bad_c[i], bad_p[i], 0, 0);
      checks++; if (reads.size() != 0) begin errors++; $display("FAIL bad_start_reads[%0d]: got %0d reads want 0", i, reads.size()); end
      checks++; if (act_lat != 1) begin errors++; $display("FAIL bad_start_latency[%0d]: got %0d want 1", i, act_lat); end
      checks++; if (act_win != 0) begin errors++; $display("FAIL bad_start_win[%0d]: got %0d want 0", i, act_win); end
    end
  endtask

  task automatic test_random();
    int r, c, p;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 42; i++) board[i] = 2'($urandom_range(0, 2));
      r = $urandom_range(0, 5);
      c = $urandom_range(0, 6);
      p = $urandom_range(1, 2);
      board[r * 7 + c] = 2'(p);
      model_scan(r, c, p);
      run_scan(r, c, p, 0, 0);
      checks++; if (act_win != exp_win) begin errors++; $display("FAIL rand_win[%0d]: got %0d want %0d", n, act_win, exp_win); end
      checks++; if (act_dir != exp_dir) begin errors++; $display("FAIL rand_dir[%0d]: got %0d want %0d", n, act_dir, exp_dir); end
      checks++; if (act_lat != exp_lat) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, act_lat, exp_lat); end
      checks++; if (!reads_equal()) begin errors++; $display("FAIL rand_reads[%0d]: got %s want %s", n, fmt_q(0), fmt_q(1)); end
      checks++; if (done_after != 0) begin errors++; $display("FAIL rand_done_width[%0d]: got %0d want 0", n, done_after); end
    end
  endtask

  initial begin
    Reset = 1'b1;
    start = 1'b0;
    row = 3'd0;
    col = 3'd0;
    player = 2'b00;
    clear_board();
    test_reset();
    test_empty_board();
    test_horizontal_win();
    test_vertical_win();
    test_color_check();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_scan();
    test_bad_start();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
